// File: rtl/sm_step_ctrl_pkg.sv
// Shared definitions for the schoolMIPS run/step/breakpoint clock controller.
// The state encoding is also decoded by the board display mux.
package sm_step_ctrl_pkg;

  typedef enum logic [1:0] {
    SM_ST_IDLE  = 2'd0,
    SM_ST_RUN   = 2'd1,
    SM_ST_STEP  = 2'd2,
    SM_ST_BREAK = 2'd3
  } sm_state_e;

  // States in which the tick counter advances and cpuEn may be issued.
  function automatic logic sm_is_active(input sm_state_e s);
    return (s == SM_ST_RUN) || (s == SM_ST_STEP);
  endfunction

  // States reported as halted to the board.
  function automatic logic sm_is_halted(input sm_state_e s);
    return (s == SM_ST_IDLE) || (s == SM_ST_BREAK);
  endfunction

endpackage

// File: rtl/sm_tick_gen.sv
// Divided-rate tick generator: counts while enabled and fires when the count
// reaches 2^(SHIFT+devide)-1, then wraps to zero.
module sm_tick_gen #(
  parameter int unsigned SHIFT = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic       clkIn,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] devide,
  output logic       tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cntr;
  logic [CNT_W-1:0] limit;

  // Compare with >= so that shrinking the period mid-count fires on the next
  // cycle instead of waiting for a counter wrap.
  assign limit = (ONE << (SHIFT + 32'(devide))) - ONE;
  assign tick  = en && (cntr >= limit);

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cntr <= '0;
    end else if (clr || tick) begin
      cntr <= '0;
    end else if (en) begin
      cntr <= cntr + ONE;
    end
  end

endmodule

// File: rtl/sm_step_ctrl.sv
// Run/step/breakpoint controller: replaces the free-running CPU clock with a
// one-cycle enable issued at the divided rate while running or stepping.
module sm_step_ctrl
  import sm_step_ctrl_pkg::*;
#(
  parameter int unsigned SHIFT = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic [3:0]  devide,
  input  logic        runReq,
  input  logic        stepReq,
  input  logic        haltReq,
  input  logic        bpEnable,
  input  logic [31:0] bpAddr,
  input  logic [31:0] imAddr,
  output logic        cpuEn,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] instrCnt
);

  sm_state_e st;
  logic      run_prev;
  logic      step_prev;
  logic      skip;
  logic      run_edge;
  logic      step_edge;
  logic      bp_hit;
  logic      tick;
  logic      tick_en;
  logic      tick_clr;

  assign run_edge  = runReq & ~run_prev;
  assign step_edge = stepReq & ~step_prev;
  assign bp_hit    = bpEnable && (imAddr == bpAddr) && !skip;
  assign state     = st;

  // IDLE and BREAK are the only states that accept run/step edges, so every
  // entry into RUN or STEP is exactly this condition.
  assign tick_en  = sm_is_active(st);
  assign tick_clr = !tick_en && !haltReq && (run_edge || step_edge);

  sm_tick_gen #(
    .SHIFT (SHIFT),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clkIn  (clkIn),
    .rst_n  (rst_n),
    .en     (tick_en),
    .clr    (tick_clr),
    .devide (devide),
    .tick   (tick)
  );

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      st        <= SM_ST_IDLE;
      cpuEn     <= 1'b0;
      halted    <= 1'b1;
      instrCnt  <= '0;
      skip      <= 1'b0;
      run_prev  <= 1'b1;
      step_prev <= 1'b1;
    end else begin
      run_prev  <= runReq;
      step_prev <= stepReq;
      cpuEn     <= 1'b0;
      case (st)
        SM_ST_IDLE, SM_ST_BREAK: begin
          if (haltReq) begin
            st     <= SM_ST_IDLE;
            halted <= 1'b1;
          end else if (run_edge) begin
            // Resuming from a breakpoint must execute the trapped instruction.
            if (st == SM_ST_BREAK) skip <= 1'b1;
            st     <= SM_ST_RUN;
            halted <= 1'b0;
          end else if (step_edge) begin
            st     <= SM_ST_STEP;
            halted <= 1'b0;
          end
        end
        SM_ST_RUN: begin
          if (haltReq) begin
            st     <= SM_ST_IDLE;
            halted <= 1'b1;
          end else if (tick) begin
            if (bp_hit) begin
              st     <= SM_ST_BREAK;
              halted <= 1'b1;
            end else begin
              cpuEn    <= 1'b1;
              instrCnt <= instrCnt + 32'd1;
              skip     <= 1'b0;
            end
          end
        end
        SM_ST_STEP: begin
          if (haltReq) begin
            st     <= SM_ST_IDLE;
            halted <= 1'b1;
          end else if (tick) begin
            cpuEn    <= 1'b1;
            instrCnt <= instrCnt + 32'd1;
            st       <= SM_ST_IDLE;
            halted   <= 1'b1;
          end
        end
        default: begin
          st     <= SM_ST_IDLE;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Scoreboard bench for sm_step_ctrl: a behavioural model predicts pulse cycles
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_sm_step_ctrl;

  localparam int SHIFT = 2;

  logic        clkIn = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  devide = 4'd0;
  logic        runReq = 1'b1;
  logic        stepReq = 1'b0;
  logic        haltReq = 1'b0;
  logic        bpEnable = 1'b0;
  logic [31:0] bpAddr = 32'h10;
  logic [31:0] imAddr = 32'h0;
  logic        cpuEn;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] instrCnt;

  always #5 clkIn = ~clkIn;

  sm_step_ctrl #(
    .SHIFT (SHIFT),
    .CNT_W (32)
  ) dut (
    .clkIn    (clkIn),
    .rst_n    (rst_n),
    .devide   (devide),
    .runReq   (runReq),
    .stepReq  (stepReq),
    .haltReq  (haltReq),
    .bpEnable (bpEnable),
    .bpAddr   (bpAddr),
    .imAddr   (imAddr),
    .cpuEn    (cpuEn),
    .state    (state),
    .halted   (halted),
    .instrCnt (instrCnt)
  );

  int          n_vec = 0;
  int          n_err = 0;

  // Reference model: mode 0 idle, 1 run, 2 step, 3 break
  int          m_mode = 0;
  int          m_age = 0;
  bit          m_skip = 0;
  logic [31:0] m_cnt = '0;
  bit          m_prun = 1;
  bit          m_pstep = 1;
  int          m_cyc = 0;
  int          exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_pulse();
    m_cnt = m_cnt + 32'd1;
    exp_q.push_back(m_cyc);
  endtask

  task automatic model_step();
    bit re, se, due;
    int period;
    re      = runReq && !m_prun;
    se      = stepReq && !m_pstep;
    m_prun  = runReq;
    m_pstep = stepReq;
    period  = 1 << (SHIFT + int'(devide));
    due     = (m_age + 1 >= period);
    case (m_mode)
      0, 3: begin
        if (haltReq) m_mode = 0;
        else if (re) begin
          if (m_mode == 3) m_skip = 1;
          m_mode = 1;
          m_age  = 0;
        end else if (se) begin
          m_mode = 2;
          m_age  = 0;
        end
      end
      1: begin
        if (haltReq) m_mode = 0;
        else if (due) begin
          m_age = 0;
          if (bpEnable && imAddr == bpAddr && !m_skip) m_mode = 3;
          else begin
            model_pulse();
            m_skip = 0;
          end
        end else m_age++;
      end
      default: begin
        if (haltReq) m_mode = 0;
        else if (due) begin
          model_pulse();
          m_mode = 0;
        end else m_age++;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clkIn or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_skip = 0; m_cnt = '0;
      m_prun = 1; m_pstep = 1;
      exp_q.delete();
    end else begin
      m_cyc++;
      model_step();
    end
  end

  // Monitor
  initial forever begin
    @(negedge clkIn);
    if (!rst_n) begin
      chk("rst_cpuEn", {31'd0, cpuEn}, 32'd0);
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd1);
      chk("rst_instrCnt", instrCnt, 32'd0);
    end else begin
      if (cpuEn) begin
        if (exp_q.size() == 0) chk("cpuEn_unexpected", {31'd0, cpuEn}, 32'd0);
        else chk("cpuEn_cycle", m_cyc, exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0] <= m_cyc) begin
        chk("cpuEn_missing", {31'd0, cpuEn}, 32'd1);
        void'(exp_q.pop_front());
      end
      chk("state", {30'd0, state}, m_mode);
      chk("halted", {31'd0, halted}, {31'd0, (m_mode == 0 || m_mode == 3)});
      chk("instrCnt", instrCnt, m_cnt);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  task automatic run_edge();
    runReq = 1'b0; cycles(1);
    runReq = 1'b1; cycles(1);
    runReq = 1'b0;
  endtask

  task automatic halt_pulse();
    haltReq = 1'b1; cycles(1);
    haltReq = 1'b0; cycles(1);
  endtask

  initial begin
    bit found;
    // runReq held high through reset release must not start a run
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    runReq = 1'b0;
    cycles(2);

    // free run, then halt
    run_edge();
    cycles(16);
    halt_pulse();

    // single step with stepReq held high
    stepReq = 1'b1;
    cycles(20);
    stepReq = 1'b0;
    cycles(2);

    // breakpoint hit, resume past it
    bpEnable = 1'b1; bpAddr = 32'h10; imAddr = 32'h10;
    run_edge();
    cycles(10);
    run_edge();
    cycles(6);
    imAddr = 32'h14;
    cycles(10);

    // halt together with run/step edges
    runReq = 1'b0; stepReq = 1'b0; cycles(1);
    haltReq = 1'b1; runReq = 1'b1; stepReq = 1'b1; cycles(1);
    haltReq = 1'b0; cycles(6);
    runReq = 1'b0; stepReq = 1'b0; cycles(1);

    // period shrink mid-count
    bpEnable = 1'b0; devide = 4'd3;
    run_edge();
    cycles(20);
    devide = 4'd0;
    cycles(14);
    halt_pulse();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) runReq = ~runReq;
      if ($urandom_range(23) == 0) stepReq = ~stepReq;
      haltReq = ($urandom_range(59) == 0);
      if ($urandom_range(99) == 0) devide = 4'($urandom_range(3));
      imAddr = 32'h10 + 32'(4 * $urandom_range(3));
      if ($urandom_range(49) == 0) bpEnable = ($urandom_range(3) != 0);
      cycles(1);
    end

    // asynchronous reset while cpuEn is high
    haltReq = 1'b0; stepReq = 1'b0; devide = 4'd0; bpEnable = 1'b0;
    halt_pulse();
    runReq = 1'b0; cycles(1);
    runReq = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clkIn);
      if (cpuEn) found = 1;
    end
    if (!found) chk("wait_cpuEn", {31'd0, cpuEn}, 32'd1);
    else begin
      #2 rst_n = 1'b0;
      #1;
      chk("async_cpuEn", {31'd0, cpuEn}, 32'd0);
      chk("async_instrCnt", instrCnt, 32'd0);
    end
    cycles(3);
    rst_n = 1'b1;
    cycles(30);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
